// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for the bit-serial subtractor.
// The master drives the request; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin using one full-subtractor cell, LSB first, one bit per clock.
// state  | meaning
// IDLE   | waiting for start
// RUN    | one operand bit processed per edge
// DONE   | one-cycle result strobe; start here begins the next run
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             a_bit, b_bit, d_bit, br_nxt, last_bit;
    logic [WIDTH-1:0] res_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Operands shift right, so bit 0 is always the bit under process and,
    // on the final edge, it is the original MSB needed for the overflow rule.
    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        d_bit    = a_bit ^ b_bit ^ br_q;
        br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        res_nxt  = {d_bit, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nxt;
                res_d = res_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d  = res_nxt;
                    bout_d  = br_nxt;
                    ovf_d   = (a_bit != b_bit) & (d_bit != a_bit);
                    zero_d  = (res_nxt == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 8 (directed + random), 2 (exhaustive) and 16 (random).
module tb_serial_subtractor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n8;
    logic rst_no;

    serial_subtractor_if #(.WIDTH(8))  if8 ();
    serial_subtractor_if #(.WIDTH(2))  if2 ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();

    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n8), .bus(if8));
    serial_subtractor #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_no), .bus(if2));
    serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_no), .bus(if16));

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t q16[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, borrow from the sign of the true result.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic bin);
        longint full;
        longint mask;
        exp_t   e;
        mask   = (longint'(1) << w) - 1;
        full   = longint'(a) - longint'(b) - longint'(bin);
        e.diff = 32'(full & mask);
        e.bout = (full < 0);
        e.ovf  = (a[w-1] != b[w-1]) && (e.diff[w-1] != a[w-1]);
        e.zero = (e.diff == 32'd0);
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] diff,
                       input logic bout, input logic ovf, input logic zero);
        chk({tag, " diff"}, diff, e.diff);
        chk({tag, " bout"}, 32'(bout), 32'(e.bout));
        chk({tag, " ovf"},  32'(ovf),  32'(e.ovf));
        chk({tag, " zero"}, 32'(zero), 32'(e.zero));
    endtask

    task automatic unexpected(input string tag);
        checks++;
        failures++;
        $display("FAIL %s unexpected_done actual=done required=no_pending_op", tag);
    endtask

    // Monitors: one per instance, popping the scoreboard whenever done is seen.
    logic pd8 = 1'b0, pd2 = 1'b0, pd16 = 1'b0;

    always @(negedge clk) begin : mon8
        exp_t e;
        if (if8.done) begin
            chk("w8 done_busy_excl", 32'(if8.busy), 32'd0);
            chk("w8 done_width", 32'(pd8), 32'd0);
            if (q8.size() == 0) unexpected("w8");
            else begin
                e = q8.pop_front();
                cmp("w8", e, 32'(if8.diff), if8.bout, if8.ovf, if8.zero);
            end
        end
        pd8 = if8.done;
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (if2.done) begin
            chk("w2 done_busy_excl", 32'(if2.busy), 32'd0);
            chk("w2 done_width", 32'(pd2), 32'd0);
            if (q2.size() == 0) unexpected("w2");
            else begin
                e = q2.pop_front();
                cmp("w2", e, 32'(if2.diff), if2.bout, if2.ovf, if2.zero);
            end
        end
        pd2 = if2.done;
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (if16.done) begin
            chk("w16 done_busy_excl", 32'(if16.busy), 32'd0);
            chk("w16 done_width", 32'(pd16), 32'd0);
            if (q16.size() == 0) unexpected("w16");
            else begin
                e = q16.pop_front();
                cmp("w16", e, 32'(if16.diff), if16.bout, if16.ovf, if16.zero);
            end
        end
        pd16 = if16.done;
    end

    // Called at a negedge; returns one time unit after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input bit push);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bin;
        if (push) q8.push_back(model(8, 32'(a), 32'(b), bin));
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.bin   = 1'($urandom);
    endtask

    // Waits for done; k0/b0 are negedges and busy cycles already consumed.
    task automatic wait8(input int k0, input int b0);
        int k;
        int bc;
        k  = k0;
        bc = b0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (if8.done) break;
            if (if8.busy) bc++;
        end
        chk("w8 latency", 32'(k - 1), 32'd8);
        chk("w8 busy_cycles", 32'(bc), 32'd8);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        issue8(a, b, bin, 1'b1);
        wait8(0, 0);
    endtask

    task automatic seq8();
        run8(8'h5A, 8'h3C, 1'b0);
        chk("w8 5A-3C diff", 32'(if8.diff), 32'h1E);
        run8(8'h00, 8'h01, 1'b0);
        run8(8'h80, 8'h01, 1'b0);
        chk("w8 80-01 ovf", 32'(if8.ovf), 32'd1);
        run8(8'h7F, 8'hFF, 1'b0);
        run8(8'h01, 8'h00, 1'b1);
        chk("w8 01-00-1 zero", 32'(if8.zero), 32'd1);
        run8(8'h00, 8'h00, 1'b1);
        chk("w8 00-00-1 diff", 32'(if8.diff), 32'hFF);

        // Start pulse while busy must be ignored; then back-to-back from done.
        @(negedge clk);
        issue8(8'h10, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if8.start = 1'b1;
        if8.a     = 8'hFF;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        wait8(2, 2);
        chk("w8 ignored_start diff", 32'(if8.diff), 32'h0F);
        run8(8'h05, 8'h03, 1'b0);
        chk("w8 back_to_back diff", 32'(if8.diff), 32'h02);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        issue8(8'h33, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n8 = 1'b0;
        #1;
        chk("w8 rst busy", 32'(if8.busy), 32'd0);
        chk("w8 rst done", 32'(if8.done), 32'd0);
        chk("w8 rst diff", 32'(if8.diff), 32'd0);
        chk("w8 rst bout", 32'(if8.bout), 32'd0);
        chk("w8 rst ovf",  32'(if8.ovf),  32'd0);
        chk("w8 rst zero", 32'(if8.zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n8 = 1'b1;
        repeat (12) @(negedge clk);
        run8(8'h03, 8'h05, 1'b0);
        chk("w8 03-05 diff", 32'(if8.diff), 32'hFE);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run8(8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic seq2();
        int k;
        for (int i = 0; i < 32; i++) begin
            logic [1:0] a;
            logic [1:0] b;
            logic       bin;
            a   = 2'(i >> 3);
            b   = 2'(i >> 1);
            bin = 1'(i);
            if2.start = 1'b1;
            if2.a     = a;
            if2.b     = b;
            if2.bin   = bin;
            q2.push_back(model(2, 32'(a), 32'(b), bin));
            @(posedge clk);
            #1;
            if2.start = 1'b0;
            if2.a     = 2'($urandom);
            if2.b     = 2'($urandom);
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                k++;
                if (if2.done) break;
            end
            chk("w2 latency", 32'(k - 1), 32'd2);
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic seq16();
        int k;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic        bin;
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
            if (i == 0) begin
                a = 16'h8000;
                b = 16'h0000;
                bin = 1'b1;
            end
            if16.start = 1'b1;
            if16.a     = a;
            if16.b     = b;
            if16.bin   = bin;
            q16.push_back(model(16, 32'(a), 32'(b), bin));
            @(posedge clk);
            #1;
            if16.start = 1'b0;
            if16.a     = 16'($urandom);
            if16.b     = 16'($urandom);
            k = 0;
            while (k < 40) begin
                @(negedge clk);
                k++;
                if (if16.done) break;
            end
            chk("w16 latency", 32'(k - 1), 32'd16);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.bin  = 1'b0;
        if2.start  = 1'b0; if2.a  = '0; if2.b  = '0; if2.bin  = 1'b0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
        rst_n8 = 1'b0;
        rst_no = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(if8.busy), 32'd0);
        chk("reset done", 32'(if8.done), 32'd0);
        chk("reset diff", 32'(if8.diff), 32'd0);
        chk("reset bout", 32'(if8.bout), 32'd0);
        chk("reset ovf",  32'(if8.ovf),  32'd0);
        chk("reset zero", 32'(if8.zero), 32'd0);
        rst_n8 = 1'b1;
        rst_no = 1'b1;
        @(negedge clk);
        fork
            seq8();
            seq2();
            seq16();
        join
        repeat (4) @(negedge clk);
        chk("w8 pending_ops",  32'(q8.size()),  32'd0);
        chk("w2 pending_ops",  32'(q2.size()),  32'd0);
        chk("w16 pending_ops", 32'(q16.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
